// File: rtl/fa4_autocheck.sv
// fa4_autocheck: self-checking harness for 4-bit full-adder DUTs.
// It generates {ci,a,b} vectors from a 9-bit LFSR and drives them to the DUT.
// After a settle window it samples s/co and compares them against a golden sum.
// It accumulates an error count and captures the first failing vector.
//
// Optional feature macro: FA4_DUAL_EN
//   When defined, a second DUT (dut2_s/dut2_co) is checked in the same run.
//   Per-DUT sticky mismatch flags are reported on mism_dut.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-high reset
//   start            in   1-cycle pulse, begins a run from IDLE or DONE
//   drv_a/drv_b      out  4-bit operands to the DUT
//   drv_ci           out  carry-in to the DUT
//   dut_s/dut_co     in   DUT sum / carry-out
//   dut2_s/dut2_co   in   second DUT sum / carry-out (FA4_DUAL_EN only)
//   mism_dut         out  sticky per-DUT mismatch flags (FA4_DUAL_EN only)
//   busy             out  high while a vector is in flight (DRIVE/SETTLE/CHECK)
//   done             out  high in DONE
//   pass             out  valid with done; 1 iff no vector mismatched
//   err_cnt          out  mismatching vectors, saturating at 255
//   vec_cnt          out  vectors checked in the current run
//   fail_vec         out  {ci,a,b} of the first mismatch, 0 if none
module fa4_autocheck #(
  parameter int unsigned NUM_VEC = 10,
  parameter int unsigned SETTLE  = 2,
  parameter logic [8:0]  SEED    = 9'h1A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] drv_a,
  output logic [3:0] drv_b,
  output logic       drv_ci,
  input  logic [3:0] dut_s,
  input  logic       dut_co,
`ifdef FA4_DUAL_EN
  input  logic [3:0] dut2_s,
  input  logic       dut2_co,
  output logic [1:0] mism_dut,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] vec_cnt,
  output logic [8:0] fail_vec
);

  // Settle counter only has to hold SETTLE-1.
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  logic [8:0]      r_lfsr;
  logic [SW-1:0]   r_settle;
  logic [3:0]      r_drv_a;
  logic [3:0]      r_drv_b;
  logic            r_drv_ci;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [7:0]      r_err_cnt;
  logic [7:0]      r_vec_cnt;
  logic [8:0]      r_fail_vec;
`ifdef FA4_DUAL_EN
  logic [1:0]      r_mism_dut;
`endif

  logic [4:0]      w_expected;
  logic            w_mism1;
  logic            w_mism2;
  logic            w_mism;
  logic [8:0]      w_lfsr_next;
  logic [7:0]      w_vec_next;
  logic [7:0]      w_err_next;

  // Golden sum, zero-extended to 5 bits so the carry lands in bit 4.
  assign w_expected = 5'(r_drv_a) + 5'(r_drv_b) + 5'(r_drv_ci);
  assign w_mism1    = ({dut_co, dut_s} != w_expected);
`ifdef FA4_DUAL_EN
  assign w_mism2    = ({dut2_co, dut2_s} != w_expected);
`else
  assign w_mism2    = 1'b0;
`endif
  assign w_mism     = w_mism1 | w_mism2;

  // Fibonacci LFSR, x^9 + x^5 + 1: feedback from taps 8 and 4 into bit 0.
  assign w_lfsr_next = {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
  assign w_vec_next  = r_vec_cnt + 8'd1;
  assign w_err_next  = (r_err_cnt == 8'hFF) ? r_err_cnt : (r_err_cnt + 8'd1);

  // Sequencer: vector generation, sampling, scoring and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_settle   <= '0;
      r_drv_a    <= 4'd0;
      r_drv_b    <= 4'd0;
      r_drv_ci   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_vec_cnt  <= 8'd0;
      r_fail_vec <= 9'd0;
`ifdef FA4_DUAL_EN
      r_mism_dut <= 2'b00;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A new run clears results; the drive lines keep the last vector.
          if (start) begin
            r_state    <= S_DRIVE;
            r_lfsr     <= SEED;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_vec_cnt  <= 8'd0;
            r_fail_vec <= 9'd0;
`ifdef FA4_DUAL_EN
            r_mism_dut <= 2'b00;
`endif
          end
        end

        S_DRIVE: begin
          {r_drv_ci, r_drv_a, r_drv_b} <= r_lfsr;
          r_settle <= SW'(SETTLE - 1);
          r_state  <= S_SETTLE;
        end

        S_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end

        S_CHECK: begin
          if (w_mism) begin
            r_err_cnt <= w_err_next;
            // Only the first failure of the run is captured.
            if (r_err_cnt == 8'd0) begin
              r_fail_vec <= {r_drv_ci, r_drv_a, r_drv_b};
            end
          end
`ifdef FA4_DUAL_EN
          r_mism_dut <= r_mism_dut | {w_mism2, w_mism1};
`endif
          r_vec_cnt <= w_vec_next;
          r_lfsr    <= w_lfsr_next;
          if (w_vec_next == 8'(NUM_VEC)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            // Include this vector's result in the pass decision.
            r_pass  <= (r_err_cnt == 8'd0) && !w_mism;
          end else begin
            r_state <= S_DRIVE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign drv_a    = r_drv_a;
  assign drv_b    = r_drv_b;
  assign drv_ci   = r_drv_ci;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign vec_cnt  = r_vec_cnt;
  assign fail_vec = r_fail_vec;
`ifdef FA4_DUAL_EN
  assign mism_dut = r_mism_dut;
`endif

endmodule
